// File: rtl/cpu8_pkg.sv
// Shared constants for the 8-bit CPU arithmetic unit: operation codes,
// FSM state encodings and default datapath widths.
package cpu8_pkg;

    localparam int CPU8_WIDTH   = 8;
    localparam int CPU8_SHCNT_W = 3;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_SHR = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cpu8_muldiv_step.sv
// One iteration of the shared hi/lo datapath: shift-add multiply, restoring
// divide, or a single-bit logical shift, selected by op.
module cpu8_muldiv_step
    import cpu8_pkg::*;
#(
    parameter int WIDTH = CPU8_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             shout
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] diff;

    // Divide keeps hi < b, so a non-negative trial difference always fits WIDTH bits.
    assign sum  = {1'b0, hi} + {1'b0, b};
    assign rem  = {hi, lo[WIDTH-1]};
    assign diff = rem[WIDTH-1:0] - b;

    always_comb begin
        hi_next = hi;
        lo_next = lo;
        shout   = 1'b0;
        case (op)
            OP_MUL: begin
                if (lo[0]) begin
                    {hi_next, lo_next} = {sum, lo[WIDTH-1:1]};
                end else begin
                    {hi_next, lo_next} = {1'b0, hi, lo[WIDTH-1:1]};
                end
            end
            OP_DIV: begin
                if (rem >= {1'b0, b}) begin
                    hi_next = diff;
                    lo_next = {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi_next = rem[WIDTH-1:0];
                    lo_next = {lo[WIDTH-2:0], 1'b0};
                end
            end
            OP_SHL: begin
                lo_next = {lo[WIDTH-2:0], 1'b0};
                shout   = lo[WIDTH-1];
            end
            default: begin
                lo_next = {1'b0, lo[WIDTH-1:1]};
                shout   = lo[0];
            end
        endcase
    end

endmodule

// File: rtl/cpu8_muldiv_unit.sv
// Multi-cycle MUL/DIV/SHL/SHR unit: one bit per clock on a shared hi/lo
// register pair, BUSY while iterating, single-cycle DONE pulse at the end.
module cpu8_muldiv_unit
    import cpu8_pkg::*;
#(
    parameter int WIDTH   = CPU8_WIDTH,
    parameter int SHCNT_W = CPU8_SHCNT_W
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             OVF,
    output logic             DIV0
);

    localparam int CNT_W = ($clog2(WIDTH + 1) > SHCNT_W) ? $clog2(WIDTH + 1) : SHCNT_W;

    logic [1:0]       state_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;
    logic             div0_reg;

    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic             shout;
    logic [CNT_W-1:0] shamt;

    assign shamt = CNT_W'(B[SHCNT_W-1:0]);

    cpu8_muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op      (op_reg),
        .hi      (hi_reg),
        .lo      (lo_reg),
        .b       (b_reg),
        .hi_next (hi_next),
        .lo_next (lo_next),
        .shout   (shout)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_MUL;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            div0_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    hi_reg  <= hi_next;
                    lo_reg  <= lo_next;
                    ovf_reg <= ovf_reg | shout;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    if (START) begin
                        op_reg   <= OP;
                        b_reg    <= B;
                        ovf_reg  <= 1'b0;
                        div0_reg <= 1'b0;
                        hi_reg   <= '0;
                        lo_reg   <= A;
                        case (OP)
                            OP_MUL: begin
                                cnt_reg   <= CNT_W'(WIDTH);
                                state_reg <= ST_RUN;
                            end
                            OP_DIV: begin
                                // Divide by zero resolves immediately with a saturated quotient.
                                if (B == '0) begin
                                    div0_reg  <= 1'b1;
                                    lo_reg    <= '1;
                                    hi_reg    <= A;
                                    cnt_reg   <= '0;
                                    state_reg <= ST_DONE;
                                end else begin
                                    cnt_reg   <= CNT_W'(WIDTH);
                                    state_reg <= ST_RUN;
                                end
                            end
                            default: begin
                                cnt_reg   <= shamt;
                                state_reg <= (shamt == '0) ? ST_DONE : ST_RUN;
                            end
                        endcase
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Multiply overflow is simply a non-zero high byte; shifts use the sticky bit.
    assign BUSY      = (state_reg == ST_RUN);
    assign DONE      = (state_reg == ST_DONE);
    assign RESULT    = lo_reg;
    assign RESULT_HI = hi_reg;
    assign OVF       = (op_reg == OP_MUL) ? (|hi_reg) : ovf_reg;
    assign DIV0      = div0_reg;

endmodule

// File: tb/tb_cpu8_muldiv_unit.sv
// Scoreboard bench for cpu8_muldiv_unit: directed operations push expected
// results; a negedge monitor pops and compares on every DONE pulse.
module tb_cpu8_muldiv_unit;

    localparam logic [1:0] T_MUL = 2'b00;
    localparam logic [1:0] T_DIV = 2'b01;
    localparam logic [1:0] T_SHL = 2'b10;
    localparam logic [1:0] T_SHR = 2'b11;

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic       ovf;
        logic       div0;
        int         busy;
    } exp_t;

    logic       clk;
    logic       clr;
    logic       start;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       ovf;
    logic       div0;

    int   checks     = 0;
    int   failures   = 0;
    int   busy_cnt   = 0;
    int   done_count = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    cpu8_muldiv_unit #(
        .WIDTH   (8),
        .SHCNT_W (3)
    ) dut (
        .CLK       (clk),
        .CLR       (clr),
        .START     (start),
        .OP        (op),
        .A         (a),
        .B         (b),
        .BUSY      (busy),
        .DONE      (done),
        .RESULT    (result),
        .RESULT_HI (result_hi),
        .OVF       (ovf),
        .DIV0      (div0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Monitor: count BUSY cycles, compare everything on DONE.
    always @(negedge clk) begin
        if (busy) begin
            busy_cnt++;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done got=DONE expected=no DONE");
            end else begin
                mon_e = exp_q.pop_front();
                $display("txn done: RESULT=%02h RESULT_HI=%02h OVF=%0d DIV0=%0d busy_cycles=%0d",
                         result, result_hi, ovf, div0, busy_cnt);
                check("result",    32'(result),    32'(mon_e.res));
                check("result_hi", 32'(result_hi), 32'(mon_e.hi));
                check("ovf",       32'(ovf),       32'(mon_e.ovf));
                check("div0",      32'(div0),      32'(mon_e.div0));
                check("busy_cycles", 32'(busy_cnt), 32'(mon_e.busy));
            end
            busy_cnt = 0;
            done_count++;
        end else begin
            busy_cnt = 0;
        end
    end

    task automatic wait_done(input int cnt0);
        for (int i = 0; i < 30 && done_count == cnt0; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (done_count == cnt0) begin
            failures++;
            $display("FAIL done_timeout got=no DONE expected=DONE within 30 cycles");
        end
    endtask

    // Issue one op; returns in the DONE cycle so the next call starts back-to-back unless gap > 0.
    task automatic run_op(input logic [1:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                          input logic [7:0] e_res, input logic [7:0] e_hi, input logic e_ovf,
                          input logic e_div0, input int e_busy, input int gap);
        exp_t e;
        int   cnt0;
        e.res  = e_res;
        e.hi   = e_hi;
        e.ovf  = e_ovf;
        e.div0 = e_div0;
        e.busy = e_busy;
        cnt0   = done_count;
        exp_q.push_back(e);
        start = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_done(cnt0);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int cnt0;
        exp_t e;
        clr   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_result_hi", 32'(result_hi), 32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_div0",      32'(div0),      32'd0);
        #1;
        clr = 1'b0;

        run_op(T_MUL, 8'd13,  8'd11,  8'h8F, 8'h00, 1'b0, 1'b0, 8, 2);
        check("hold_result",    32'(result),    32'h8F);
        check("hold_result_hi", 32'(result_hi), 32'h00);
        check("hold_idle_done", 32'(done),      32'd0);
        run_op(T_MUL, 8'd200, 8'd3,   8'h58, 8'h02, 1'b1, 1'b0, 8, 0);
        run_op(T_DIV, 8'd100, 8'd7,   8'd14, 8'd2,  1'b0, 1'b0, 8, 0);
        run_op(T_DIV, 8'h55,  8'd0,   8'hFF, 8'h55, 1'b0, 1'b1, 0, 0);
        run_op(T_SHL, 8'h81,  8'd3,   8'h08, 8'h00, 1'b1, 1'b0, 3, 0);
        run_op(T_SHR, 8'h81,  8'd1,   8'h40, 8'h00, 1'b1, 1'b0, 1, 0);
        run_op(T_SHL, 8'h81,  8'd0,   8'h81, 8'h00, 1'b0, 1'b0, 0, 0);
        run_op(T_SHR, 8'hF0,  8'd8,   8'hF0, 8'h00, 1'b0, 1'b0, 0, 0);
        run_op(T_SHL, 8'h01,  8'd2,   8'h04, 8'h00, 1'b0, 1'b0, 2, 0);
        run_op(T_SHR, 8'h80,  8'd7,   8'h01, 8'h00, 1'b0, 1'b0, 7, 0);
        run_op(T_MUL, 8'hFF,  8'hFF,  8'h01, 8'hFE, 1'b1, 1'b0, 8, 0);
        run_op(T_MUL, 8'h00,  8'h9A,  8'h00, 8'h00, 1'b0, 1'b0, 8, 0);
        run_op(T_DIV, 8'hFF,  8'd1,   8'hFF, 8'h00, 1'b0, 1'b0, 8, 0);
        run_op(T_DIV, 8'd5,   8'd200, 8'h00, 8'd5,  1'b0, 1'b0, 8, 1);

        // START during BUSY must not disturb the running multiply.
        e.res  = 8'h8F;
        e.hi   = 8'h00;
        e.ovf  = 1'b0;
        e.div0 = 1'b0;
        e.busy = 8;
        cnt0   = done_count;
        exp_q.push_back(e);
        start = 1'b1; op = T_MUL; a = 8'd13; b = 8'd11;
        @(negedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        start = 1'b1; op = T_DIV; a = 8'd1; b = 8'd1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(cnt0);
        repeat (2) @(negedge clk);
        #1;

        // Abort a multiply with CLR in its 4th BUSY cycle: no DONE, outputs cleared.
        cnt0  = done_count;
        start = 1'b1; op = T_MUL; a = 8'd200; b = 8'd3;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
        end
        clr = 1'b1;
        @(negedge clk);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_done",      32'(done),      32'd0);
        check("abort_result",    32'(result),    32'd0);
        check("abort_result_hi", 32'(result_hi), 32'd0);
        check("abort_ovf",       32'(ovf),       32'd0);
        check("abort_div0",      32'(div0),      32'd0);
        #1;
        clr = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check("abort_no_done", 32'(done_count), 32'(cnt0));

        run_op(T_DIV, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 8, 2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
